// File: rtl/lfsr_pkg.sv
// Shared definitions for the 16-bit Fibonacci LFSR generator and its
// receive-side sequence checker: width, default tap mask, next-state
// function and the checker state encoding.
package lfsr_pkg;

  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] DEFAULT_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  // One Fibonacci step: shift left, feedback is the parity of the tapped bits.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] w,
                                                  input logic [LFSR_W-1:0] taps);
    return {w[LFSR_W-2:0], ^(w & taps)};
  endfunction

endpackage

// File: rtl/lfsr_seq_checker.sv
// PRBS integrity monitor for a 16-bit Fibonacci LFSR stream.
// Self-seeds a predictor from the incoming words, confirms the seed over
// LOCK_CNT consecutive matches, then counts mismatches while locked.
// Lock is dropped after LOSS_CNT consecutive mismatches.
// Optional build macro LFSR_CHK_ZERO_DET_EN: an all-zero word (the LFSR
// lock-up state) sets a sticky zero_lock flag and forces re-acquisition
// instead of being counted as an error. Without it zero_lock is tied low.
module lfsr_seq_checker
  import lfsr_pkg::*;
#(
  parameter logic [LFSR_W-1:0] TAPS     = DEFAULT_TAPS,
  parameter int                LOCK_CNT = 4,
  parameter int                LOSS_CNT = 3,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              in_valid,
  input  logic [LFSR_W-1:0] in_word,
  input  logic              clr_count,
  output logic              locked,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  err_count,
  output logic              zero_lock
);

  localparam int RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(LOSS_CNT + 1);

  chk_state_t        state;
  chk_state_t        nxt_state;
  logic [LFSR_W-1:0] expected;
  logic [LFSR_W-1:0] nxt_expected;
  logic [RUN_W-1:0]  run;
  logic [RUN_W-1:0]  nxt_run;
  logic [MISS_W-1:0] miss;
  logic [MISS_W-1:0] nxt_miss;
  logic              err_evt;
  logic              zero_word;
  logic [LFSR_W-1:0] pred_next;
  logic [LFSR_W-1:0] seed_next;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign pred_next = lfsr_next(expected, TAPS);
  assign seed_next = lfsr_next(in_word, TAPS);

`ifdef LFSR_CHK_ZERO_DET_EN
  assign zero_word = in_valid && (in_word == '0);
`else
  assign zero_word = 1'b0;
`endif

  // State register: checker mode, returns to SEARCH on reset.
  always_ff @(posedge clk) begin
    if (nReset) begin
      state <= SEARCH;
    end else begin
      state <= nxt_state;
    end
  end

  // Next-state and predictor update; nothing moves on cycles without a valid word.
  always_comb begin
    nxt_state    = state;
    nxt_expected = expected;
    nxt_run      = run;
    nxt_miss     = miss;
    err_evt      = 1'b0;
    if (zero_word) begin
      // A stuck-at-zero source is a lock-up, not a bit error: restart acquisition.
      nxt_state = SEARCH;
      nxt_run   = '0;
      nxt_miss  = '0;
    end else if (in_valid) begin
      case (state)
        SEARCH: begin
          nxt_expected = seed_next;
          nxt_run      = '0;
          nxt_state    = VERIFY;
        end
        VERIFY: begin
          if (in_word == expected) begin
            nxt_run      = run + 1'b1;
            nxt_expected = pred_next;
            if (int'(run) + 1 == LOCK_CNT) begin
              nxt_state = LOCKED;
              nxt_miss  = '0;
            end
          end else begin
            // Reseed from the word just received rather than waiting for SEARCH.
            nxt_expected = seed_next;
            nxt_run      = '0;
          end
        end
        LOCKED: begin
          // Free-running predictor so a single corrupt word costs exactly one error.
          nxt_expected = pred_next;
          if (in_word == expected) begin
            nxt_miss = '0;
          end else begin
            err_evt  = 1'b1;
            nxt_miss = miss + 1'b1;
            if (int'(miss) + 1 == LOSS_CNT) begin
              nxt_state = SEARCH;
              nxt_miss  = '0;
              nxt_run   = '0;
            end
          end
        end
        default: begin
          nxt_state = SEARCH;
        end
      endcase
    end
  end

  // Output decode: lock indication follows the state register directly.
  always_comb begin
    locked = (state == LOCKED);
  end

  // Predictor, run/miss counters and registered error reporting.
  always_ff @(posedge clk) begin
    if (nReset) begin
      expected  <= '0;
      run       <= '0;
      miss      <= '0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      expected  <= nxt_expected;
      run       <= nxt_run;
      miss      <= nxt_miss;
      err_pulse <= err_evt;
      if (clr_count) begin
        err_count <= '0;
      end else if (err_evt) begin
        err_count <= sat_inc(err_count);
      end
    end
  end

`ifdef LFSR_CHK_ZERO_DET_EN
  // Sticky lock-up flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (nReset) begin
      zero_lock <= 1'b0;
    end else if (zero_word) begin
      zero_lock <= 1'b1;
    end
  end
`else
  assign zero_lock = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Testbench for lfsr_seq_checker: table-driven directed vectors, hand-written
// corner sequences and a randomized stream scored against a behavioural model.
// A second instance with a 4-bit error counter exercises saturation.
module tb_lfsr_seq_checker;

  logic        clk = 1'b0;
  logic        nReset;
  logic        in_valid;
  logic [15:0] in_word;
  logic        clr_count;
  logic        locked, err_pulse, zero_lock;
  logic [15:0] err_count;
  logic        s_locked, s_err_pulse, s_zero_lock;
  logic [3:0]  s_err_count;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  lfsr_seq_checker dut (
    .clk(clk), .nReset(nReset), .in_valid(in_valid), .in_word(in_word),
    .clr_count(clr_count), .locked(locked), .err_pulse(err_pulse),
    .err_count(err_count), .zero_lock(zero_lock)
  );

  lfsr_seq_checker #(.CNT_W(4)) dut_s (
    .clk(clk), .nReset(nReset), .in_valid(in_valid), .in_word(in_word),
    .clr_count(clr_count), .locked(s_locked), .err_pulse(s_err_pulse),
    .err_count(s_err_count), .zero_lock(s_zero_lock)
  );

  // Reference LFSR step from the tap positions 15,13,12,10.
  function automatic int tb_next(input int w);
    int fb;
    fb = ((w >> 15) ^ (w >> 13) ^ (w >> 12) ^ (w >> 10)) & 1;
    return ((w << 1) & 32'hFFFF) | fb;
  endfunction

  // Behavioural model: has_seed / is_locked flags plus predicted word and counters.
  bit m_has_seed, m_is_locked, m_pulse, m_zero;
  int m_pred, m_good_run, m_bad_run, m_cnt16, m_cnt4;

  task automatic model_reset();
    m_has_seed = 0; m_is_locked = 0; m_pulse = 0; m_zero = 0;
    m_pred = 0; m_good_run = 0; m_bad_run = 0; m_cnt16 = 0; m_cnt4 = 0;
  endtask

  task automatic model_step(input bit v, input int w, input bit clr);
    bit err;
    bit zero_hit;
    err = 0;
    zero_hit = 0;
`ifdef LFSR_CHK_ZERO_DET_EN
    zero_hit = v && (w == 0);
`endif
    if (zero_hit) begin
      m_zero = 1; m_has_seed = 0; m_is_locked = 0; m_good_run = 0; m_bad_run = 0;
    end else if (v) begin
      if (m_is_locked) begin
        if (w != m_pred) begin
          err = 1;
          m_bad_run++;
          if (m_bad_run == 3) begin
            m_is_locked = 0; m_has_seed = 0; m_bad_run = 0;
          end
        end else begin
          m_bad_run = 0;
        end
        m_pred = tb_next(m_pred);
      end else if (!m_has_seed) begin
        m_pred = tb_next(w); m_has_seed = 1; m_good_run = 0;
      end else if (w == m_pred) begin
        m_good_run++;
        m_pred = tb_next(m_pred);
        if (m_good_run == 4) begin
          m_is_locked = 1; m_bad_run = 0;
        end
      end else begin
        m_pred = tb_next(w); m_good_run = 0;
      end
    end
    m_pulse = err;
    if (clr) begin
      m_cnt16 = 0; m_cnt4 = 0;
    end else if (err) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt4 < 15) m_cnt4++;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".locked"},      int'(locked),      int'(m_is_locked));
    chk({tag, ".err_pulse"},   int'(err_pulse),   int'(m_pulse));
    chk({tag, ".err_count"},   int'(err_count),   m_cnt16);
    chk({tag, ".zero_lock"},   int'(zero_lock),   int'(m_zero));
    chk({tag, ".s_locked"},    int'(s_locked),    int'(m_is_locked));
    chk({tag, ".s_err_pulse"}, int'(s_err_pulse), int'(m_pulse));
    chk({tag, ".s_err_count"}, int'(s_err_count), m_cnt4);
    chk({tag, ".s_zero_lock"}, int'(s_zero_lock), int'(m_zero));
  endtask

  // Apply one cycle of inputs, sample 1 time unit after the edge, advance the model.
  task automatic step(input bit v, input int w, input bit clr);
    in_valid = v; in_word = 16'(w); clr_count = clr;
    @(posedge clk); #1;
    model_step(v, w, clr);
  endtask

  task automatic do_reset();
    nReset = 1'b1; in_valid = 1'b0; in_word = '0; clr_count = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nReset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit v;
    int w;
    bit clr;
    bit e_lock;
    bit e_pulse;
    int e_cnt;
  } vec_t;

  vec_t tbl[13];
  int   s[0:31];
  int   gw;

  initial begin
    s[0] = 16'hACE1;
    for (int i = 1; i < 32; i++) s[i] = tb_next(s[i-1]);

    // Clean acquisition from seed ACE1, one flipped bit, a gap, then clean again.
    for (int i = 0; i <= 8; i++) tbl[i] = '{1, s[i], 0, (i >= 4), 0, 0};
    tbl[9]  = '{1, s[9] ^ 1, 0, 1, 1, 1};
    tbl[10] = '{1, s[10], 0, 1, 0, 1};
    tbl[11] = '{0, 16'h1234, 0, 1, 0, 1};
    tbl[12] = '{1, s[11], 0, 1, 0, 1};

    chk("lfsr_next_example", s[1], 16'h59C3);

    do_reset();
    chk("reset.locked",    int'(locked),    0);
    chk("reset.err_pulse", int'(err_pulse), 0);
    chk("reset.err_count", int'(err_count), 0);
    chk("reset.zero_lock", int'(zero_lock), 0);

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].v, tbl[i].w, tbl[i].clr);
      chk($sformatf("tbl%0d.locked", i),    int'(locked),      int'(tbl[i].e_lock));
      chk($sformatf("tbl%0d.err_pulse", i), int'(err_pulse),   int'(tbl[i].e_pulse));
      chk($sformatf("tbl%0d.err_count", i), int'(err_count),   tbl[i].e_cnt);
      chk($sformatf("tbl%0d.s_count", i),   int'(s_err_count), tbl[i].e_cnt);
    end

    // Three consecutive corrupt words drop lock; reacquire after seed + 4 matches.
    for (int k = 0; k < 3; k++) begin
      step(1, s[12+k] ^ 16'h8000, 0);
      chk($sformatf("loss%0d.err_pulse", k), int'(err_pulse), 1);
      chk($sformatf("loss%0d.err_count", k), int'(err_count), 2 + k);
      chk($sformatf("loss%0d.locked", k),    int'(locked),    (k < 2) ? 1 : 0);
    end
    for (int k = 0; k < 5; k++) begin
      step(1, s[15+k], 0);
      chk($sformatf("reacq%0d.locked", k),    int'(locked),    (k == 4) ? 1 : 0);
      chk($sformatf("reacq%0d.err_count", k), int'(err_count), 4);
    end
    check_model("after_reacq");

    // Gapped clean stream acquires lock with no errors.
    do_reset();
    gw = 16'h1D2F;
    for (int k = 0; k < 5; k++) begin
      step(1, gw, 0); gw = tb_next(gw);
      check_model($sformatf("gap_v%0d", k));
      step(0, 16'hFFFF, 0);
      chk($sformatf("gap_i%0d.locked", k),    int'(locked),    (k == 4) ? 1 : 0);
      chk($sformatf("gap_i%0d.err_pulse", k), int'(err_pulse), 0);
    end
    chk("gap.err_count", int'(err_count), 0);

    // Saturation: bad,bad,good keeps lock while accumulating 16 errors.
    for (int r = 0; r < 8; r++) begin
      step(1, gw ^ 16'h0010, 0); gw = tb_next(gw); check_model("sat_b1");
      step(1, gw ^ 16'h0100, 0); gw = tb_next(gw); check_model("sat_b2");
      step(1, gw, 0);            gw = tb_next(gw); check_model("sat_g");
    end
    chk("sat.s_count_full", int'(s_err_count), 15);
    chk("sat.count16",      int'(err_count),   16);
    chk("sat.locked",       int'(locked),      1);
    step(1, gw, 1); gw = tb_next(gw);
    chk("clr.err_count",   int'(err_count),   0);
    chk("clr.s_err_count", int'(s_err_count), 0);
    step(1, gw ^ 16'h0004, 1); gw = tb_next(gw);
    chk("clr_err.err_pulse", int'(err_pulse), 1);
    chk("clr_err.err_count", int'(err_count), 0);
    check_model("clr_err");
    step(1, gw, 0); gw = tb_next(gw);
    check_model("post_clr");

    // All-zero word while locked.
    step(1, 0, 0); gw = tb_next(gw);
`ifdef LFSR_CHK_ZERO_DET_EN
    chk("zero.zero_lock", int'(zero_lock), 1);
    chk("zero.locked",    int'(locked),    0);
    chk("zero.err_count", int'(err_count), 0);
    chk("zero.err_pulse", int'(err_pulse), 0);
    step(1, gw, 0); gw = tb_next(gw);
    chk("zero.sticky", int'(zero_lock), 1);
`else
    chk("zero.zero_lock", int'(zero_lock), 0);
    chk("zero.locked",    int'(locked),    1);
    chk("zero.err_count", int'(err_count), 1);
    chk("zero.err_pulse", int'(err_pulse), 1);
`endif
    check_model("zero");

    // Reset while locked with a nonzero error count.
    for (int k = 0; k < 6; k++) begin
      step(1, gw, 0); gw = tb_next(gw);
    end
    step(1, gw ^ 16'h0002, 0); gw = tb_next(gw);
    chk("prerst.locked", int'(locked), 1);
    check_model("prerst");
    nReset = 1'b1; in_valid = 1'b1; in_word = 16'(gw); clr_count = 1'b0;
    @(posedge clk); #1;
    model_reset();
    chk("midrst.locked",    int'(locked),    0);
    chk("midrst.err_pulse", int'(err_pulse), 0);
    chk("midrst.err_count", int'(err_count), 0);
    chk("midrst.zero_lock", int'(zero_lock), 0);
    nReset = 1'b0;

    // Randomized stream against the model.
    gw = $urandom_range(1, 65535);
    for (int c = 0; c < 3000; c++) begin
      int r;
      bit clr;
      r   = $urandom_range(0, 99);
      clr = ($urandom_range(0, 99) < 3);
      if (r < 10) begin
        step(0, $urandom_range(0, 65535), clr);
      end else if (r < 18) begin
        step(1, gw ^ $urandom_range(1, 65535), clr); gw = tb_next(gw);
      end else if (r < 20) begin
        gw = $urandom_range(1, 65535);
        step(1, gw, clr); gw = tb_next(gw);
      end else begin
        step(1, gw, clr); gw = tb_next(gw);
      end
      check_model($sformatf("rnd%0d", c));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
